// File: rtl/joystick_conditioner.sv
// Two-stick input conditioner: sync, debounce, normalize and hold-to-repeat.
// Ten independent channels feeding the Nios joystick PIO inputs.
module joystick_conditioner #(
    parameter bit         ACTIVE_LOW          = 1'b1,
    parameter int         DEBOUNCE_CYCLES     = 1000000,
    parameter int         REPEAT_DELAY_CYCLES = 25000000,
    parameter int         REPEAT_RATE_CYCLES  = 5000000,
    parameter int         REPEAT_GAP_CYCLES   = 4,
    parameter logic [4:0] REPEAT_MASK         = 5'b01111
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [4:0] stick1_raw,
    input  logic [4:0] stick2_raw,
    output logic [4:0] stick1_out,
    output logic [4:0] stick2_out,
    output logic [9:0] press_strobe
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (REPEAT_DELAY_CYCLES > 1) ? $clog2(REPEAT_DELAY_CYCLES) : 1;
    localparam int GW = (REPEAT_GAP_CYCLES > 1) ? $clog2(REPEAT_GAP_CYCLES) : 1;
    localparam int RW = (REPEAT_RATE_CYCLES > 1) ? $clog2(REPEAT_RATE_CYCLES) : 1;
    localparam int TW0 = (HW > GW) ? HW : GW;
    localparam int TW = (TW0 > RW) ? TW0 : RW;

    localparam logic [9:0] MASK = {REPEAT_MASK, REPEAT_MASK};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] RATE = 2'd3;

    logic [9:0] norm;
    logic [9:0] sync1;
    logic [9:0] sync2;
    logic [9:0] on;
    logic [9:0] out;
    logic [9:0] out_d;
    logic [9:0] strobe;

    // Normalized so that 1 always means pressed from here on.
    assign norm = {stick2_raw, stick1_raw} ^ {10{ACTIVE_LOW}};

    always_ff @(posedge clk_clk) begin
        if (!reset_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= norm;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 10; i++) begin : g_ch
        logic [DW-1:0] dcnt;
        logic          stable;
        logic [1:0]    state;
        logic [TW-1:0] tmr;

        always_ff @(posedge clk_clk) begin
            if (!reset_reset) begin
                dcnt   <= '0;
                stable <= 1'b0;
            end else if (sync2[i] != stable) begin
                if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync2[i];
                    dcnt   <= '0;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end else begin
                dcnt <= '0;
            end
        end

        // Release wins over any timer expiry; unmasked bits park in HOLD.
        always_ff @(posedge clk_clk) begin
            if (!reset_reset || !stable) begin
                state <= IDLE;
                tmr   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= HOLD;
                        tmr   <= '0;
                    end
                    HOLD: begin
                        if (!MASK[i]) begin
                            tmr <= '0;
                        end else if (tmr == TW'(REPEAT_DELAY_CYCLES - 1)) begin
                            state <= GAP;
                            tmr   <= '0;
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                    GAP: begin
                        if (tmr == TW'(REPEAT_GAP_CYCLES - 1)) begin
                            state <= RATE;
                            tmr   <= '0;
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                    RATE: begin
                        if (tmr == TW'(REPEAT_RATE_CYCLES - 1)) begin
                            state <= GAP;
                            tmr   <= '0;
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tmr   <= '0;
                    end
                endcase
            end
        end

        assign on[i] = (state == HOLD) || (state == RATE);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset) begin
            out    <= '0;
            out_d  <= '0;
            strobe <= '0;
        end else begin
            out    <= on;
            out_d  <= out;
            strobe <= out & ~out_d;
        end
    end

    assign stick1_out   = out[4:0];
    assign stick2_out   = out[9:5];
    assign press_strobe = strobe;

endmodule
